// File: rtl/register_unit_pkg.sv
// Shared types and constants for the integer register file.
package register_unit_pkg;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = 5;

   typedef logic [XLEN-1:0]   word_t;
   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;
   localparam reg_addr_t REG_SP   = 5'd2;

   // True when an address names a real, writable register (never x0).
   function automatic logic is_writable(input reg_addr_t addr);
      return (addr != REG_ZERO);
   endfunction

endpackage

// File: rtl/register_unit_read_port.sv
// One combinational read port of the register file: address mux with x0
// forced to zero. When REGISTER_UNIT_BYPASS_EN is defined, a pending write
// to the same address is forwarded to the output before the clock edge.
module register_unit_read_port
   import register_unit_pkg::*;
(
   input  logic [NREGS-1:0][XLEN-1:0] regs,
   input  logic [REG_AW-1:0]          addr,
`ifdef REGISTER_UNIT_BYPASS_EN
   input  logic [REG_AW-1:0]          wr_addr,
   input  logic [XLEN-1:0]            wr_data,
   input  logic                       wr_en,
`endif
   output logic [XLEN-1:0]            rdata
);

   word_t rdata_s;

   // Select the read data; x0 always reads zero and is never forwarded.
   always_comb begin
      rdata_s = '0;
      if (addr == REG_ZERO) begin
         rdata_s = '0;
      end
`ifdef REGISTER_UNIT_BYPASS_EN
      else if (wr_en && is_writable(wr_addr) && (wr_addr == addr)) begin
         rdata_s = wr_data;
      end
`endif
      else begin
         rdata_s = regs[addr];
      end
   end

   assign rdata = rdata_s;

endmodule

// File: rtl/register_unit.sv
// Integer register file: 32 x XLEN, two combinational read ports and one
// synchronous write port. x0 reads as zero; x2 resets to SP_INIT.
// Optional macro REGISTER_UNIT_BYPASS_EN enables write-through forwarding.
module register_unit
   import register_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] SP_INIT = 32'h0000_0000
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [REG_AW-1:0] rd,
   input  logic [XLEN-1:0]   DataWr,
   input  logic              RUWr,
   output logic [XLEN-1:0]   RURs1,
   output logic [XLEN-1:0]   RURs2
);

   // Entry 0 is held at zero; the read ports never select it anyway.
   logic [NREGS-1:0][XLEN-1:0] regs_r;

`ifdef REGISTER_UNIT_BYPASS_EN
   // Reset outranks a write, so a write is not forwarded while in reset.
   logic wr_fwd_en_s;
   assign wr_fwd_en_s = RUWr & rst_n;
`endif

   // Storage: async clear (x2 loaded with SP_INIT), else capture writes to x1..x31.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_r         <= '0;
         regs_r[REG_SP] <= SP_INIT;
      end else if (RUWr && is_writable(rd)) begin
         regs_r[rd] <= DataWr;
      end
   end

   register_unit_read_port u_port1 (
      .regs    (regs_r),
      .addr    (rs1),
`ifdef REGISTER_UNIT_BYPASS_EN
      .wr_addr (rd),
      .wr_data (DataWr),
      .wr_en   (wr_fwd_en_s),
`endif
      .rdata   (RURs1)
   );

   register_unit_read_port u_port2 (
      .regs    (regs_r),
      .addr    (rs2),
`ifdef REGISTER_UNIT_BYPASS_EN
      .wr_addr (rd),
      .wr_data (DataWr),
      .wr_en   (wr_fwd_en_s),
`endif
      .rdata   (RURs2)
   );

endmodule

// File: tb/tb_register_unit.sv
// Self-checking bench for register_unit: directed vectors, a sparse-memory
// reference model compared on every falling edge, plus literal spot checks.
module tb_register_unit;

   localparam logic [31:0] SP_VAL = 32'h0000_8000;
`ifdef REGISTER_UNIT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] DataWr;
   logic        RUWr;
   logic [31:0] RURs1, RURs2;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference contents: only registers ever written exist; absent ones read 0.
   logic [31:0] mem [int];

   register_unit #(.SP_INIT(SP_VAL)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .rs1    (rs1),
      .rs2    (rs2),
      .rd     (rd),
      .DataWr (DataWr),
      .RUWr   (RUWr),
      .RURs1  (RURs1),
      .RURs2  (RURs2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model update: reset empties the file, a write to x1..x31 stores.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem.delete();
         mem[2] = SP_VAL;
      end else if (RUWr && rd != 5'd0) begin
         mem[int'(rd)] = DataWr;
      end
   end

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (BYP && rst_n && RUWr && rd == a) return DataWr;
      if (!rst_n) return (a == 5'd2) ? SP_VAL : 32'h0;
      if (mem.exists(int'(a))) return mem[int'(a)];
      return 32'h0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_rurs1", RURs1, model_read(rs1));
         check("model_rurs2", RURs2, model_read(rs2));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0; RUWr = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; DataWr = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Reset state
      rs1 = 5'd0; rs2 = 5'd1; #1;
      check("rst_x0", RURs1, 32'h0);
      check("rst_x1", RURs2, 32'h0);
      rs1 = 5'd2; #1;
      check("rst_sp", RURs1, 32'h0000_8000);
      rs1 = 5'd4; rs2 = 5'd5; #1;
      check("rst_x4", RURs1, 32'h0);
      check("rst_x5", RURs2, 32'h0);

      // Basic write/read
      rd = 5'd6; DataWr = 32'hDEADBEEF; RUWr = 1'b1;
      step();
      RUWr = 1'b0; rs1 = 5'd6; #1;
      check("wr_x6", RURs1, 32'hDEADBEEF);

      // Second write, retention, RUWr=0 holds
      rd = 5'd7; DataWr = 32'hCAFEBABE; RUWr = 1'b1;
      step();
      RUWr = 1'b0; rs1 = 5'd7; rs2 = 5'd6; #1;
      check("wr_x7", RURs1, 32'hCAFEBABE);
      check("keep_x6", RURs2, 32'hDEADBEEF);
      DataWr = 32'h1111_1111;
      step();
      check("nowr_x7", RURs1, 32'hCAFEBABE);

      // x0 protection
      rd = 5'd0; DataWr = 32'hFFFF_FFFF; RUWr = 1'b1; rs1 = 5'd0; rs2 = 5'd0; #1;
      check("x0_pre", RURs1, 32'h0);
      step();
      RUWr = 1'b0; #1;
      check("x0_post", RURs1, 32'h0);

      // Same-cycle hazard on x9
      rs1 = 5'd9; rs2 = 5'd9; rd = 5'd9; DataWr = 32'h1234_5678; RUWr = 1'b1; #1;
      check("haz_pre", RURs1, BYP ? 32'h1234_5678 : 32'h0);
      step();
      RUWr = 1'b0; #1;
      check("haz_post", RURs1, 32'h1234_5678);
      check("haz_post2", RURs2, 32'h1234_5678);

      // rs1 == rs2
      rs1 = 5'd6; rs2 = 5'd6; #1;
      check("same_p1", RURs1, 32'hDEADBEEF);
      check("same_p2", RURs2, 32'hDEADBEEF);

      // Walk all registers with distinct values
      for (int i = 1; i < 32; i++) begin
         rd = i[4:0]; DataWr = 32'hA500_0000 + i; RUWr = 1'b1;
         step();
      end
      RUWr = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1 = i[4:0]; rs2 = 5'(31 - i);
         step();
      end
      rs1 = 5'd31; rs2 = 5'd1; #1;
      check("walk_x31", RURs1, 32'hA500_001F);
      check("walk_x1", RURs2, 32'hA500_0001);

      // Async reset between edges, then a write attempted during reset
      rs1 = 5'd6; rs2 = 5'd2; #1;
      check("pre_rst_x6", RURs1, 32'hA500_0006);
      rst_n = 1'b0; #1;
      check("async_x6", RURs1, 32'h0);
      check("async_sp", RURs2, 32'h0000_8000);
      rd = 5'd6; DataWr = 32'hAAAA_5555; RUWr = 1'b1; #1;
      check("rst_nofwd", RURs1, 32'h0);
      step();
      RUWr = 1'b0;
      rst_n = 1'b1; #1;
      check("rst_wr_ign", RURs1, 32'h0);
      check("rst_sp_kept", RURs2, 32'h0000_8000);
      step();
      step();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
